// File: rtl/mm_pkg.sv
// Shared types and default sizing for the matrix-multiply result path.
package mm_pkg;

    localparam int unsigned N_DEF      = 16;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = $clog2(N_DEF * N_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } streamer_state_t;

    // Buffered result word tagged with the BRAM address it was read from.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [ADDR_W_DEF-1:0] addr;
    } buf_entry_t;

endpackage

// File: rtl/result_streamer_if.sv
// Valid/ready result stream carrying the word plus its matrix coordinates.
interface result_streamer_if
    import mm_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IDX_W  = $clog2(N_DEF)
);

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [IDX_W-1:0]  out_row;
    logic [IDX_W-1:0]  out_col;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_row,
        output out_col,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_row,
        input  out_col,
        output out_ready
    );

endinterface

// File: rtl/result_streamer_fifo2.sv
// Two-entry FIFO with the head held in a fixed register so it drives outputs directly.
module fifo2
    import mm_pkg::*;
#(
    parameter type entry_t = buf_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     push_data,
    input  logic       pop,
    output entry_t     head,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    entry_t slot0_q, slot0_d;
    entry_t slot1_q, slot1_d;
    logic   v0_q, v0_d;
    logic   v1_q, v1_d;
    logic   do_pop;

    assign do_pop = pop & v0_q;

    // Shift-style update: slot1 always moves into slot0 on a pop.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        if (do_pop) begin
            if (v1_q) begin
                slot0_d = slot1_q;
                if (push) begin
                    slot1_d = push_data;
                end else begin
                    v1_d = 1'b0;
                end
            end else if (push) begin
                slot0_d = push_data;
            end else begin
                v0_d = 1'b0;
            end
        end else if (push) begin
            if (!v0_q) begin
                slot0_d = push_data;
                v0_d    = 1'b1;
            end else if (!v1_q) begin
                slot1_d = push_data;
                v1_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
        end
    end

    assign head  = slot0_q;
    assign full  = v1_q;
    assign empty = !v0_q;
    assign count = v1_q ? 2'd2 : (v0_q ? 2'd1 : 2'd0);

endmodule

// File: rtl/result_streamer.sv
// Streams the N*N result matrix out of the result BRAM in row-major order,
// hiding the 1-cycle read latency behind a credit-controlled 2-entry buffer.
module result_streamer
    import mm_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = $clog2(N * N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q,
    result_streamer_if.master out_if
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned WORDS = N * N;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    streamer_state_t   state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              inflight_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              issue_c;

    entry_t            head;
    entry_t            push_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic              pop_c;
    logic [2:0]        occ_c;
    logic              room_c;

    assign pop_c      = !fifo_empty & out_if.out_ready;
    assign push_entry = '{data: mem_q, addr: mem_addr_q};

    // A new read is allowed only if its word is sure to find a free slot.
    assign occ_c  = 3'(fifo_count) + 3'(inflight_q);
    assign room_c = occ_c < (3'd2 + 3'(pop_c));

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
        issue_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = STREAM;
                    rd_cnt_d = '0;
                end
            end
            STREAM: begin
                if ((rd_cnt_q < CNT_W'(WORDS)) && room_c) begin
                    issue_c    = 1'b1;
                    mem_addr_d = rd_cnt_q[ADDR_W-1:0];
                    rd_cnt_d   = rd_cnt_q + CNT_W'(1);
                end
                if (rd_cnt_d == CNT_W'(WORDS)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the last word is handed off so done lands the cycle after.
                if (!inflight_q && (fifo_empty || (fifo_count == 2'd1 && pop_c))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            mem_addr_q <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            mem_addr_q <= mem_addr_d;
            inflight_q <= issue_c;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    fifo2 #(
        .entry_t(entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_data(push_entry),
        .pop      (pop_c),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_full && inflight_q && !pop_c));

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_rden = issue_c;
    assign mem_addr = issue_c ? rd_cnt_q[ADDR_W-1:0] : mem_addr_q;

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = head.data;
    assign out_if.out_row   = IDX_W'(head.addr >> IDX_W);
    assign out_if.out_col   = head.addr[IDX_W-1:0];
    assign out_if.out_last  = (head.addr == ADDR_W'(WORDS - 1));

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: scenario table with random backpressure
// against a row-major reference stream, plus abort/restart and a small-N build.
module tb_result_streamer;
    import mm_pkg::*;

    localparam int unsigned WA = 256;
    localparam int unsigned WB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, busy_a, done_a, rden_a;
    logic [7:0]  addr_a;
    logic [31:0] q_a = '0;
    logic        start_b = 1'b0, busy_b, done_b, rden_b;
    logic [3:0]  addr_b;
    logic [15:0] q_b = '0;

    logic [31:0] mem_a [WA];
    logic [15:0] mem_b [WB];

    result_streamer_if #(.DATA_W(32), .IDX_W(4)) sa ();
    result_streamer_if #(.DATA_W(16), .IDX_W(2)) sb ();

    result_streamer #(.N(16), .DATA_W(32), .ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_addr(addr_a), .mem_rden(rden_a), .mem_q(q_a), .out_if(sa)
    );

    result_streamer #(.N(4), .DATA_W(16), .ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_addr(addr_b), .mem_rden(rden_b), .mem_q(q_b), .out_if(sb)
    );

    // BRAM models: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (rden_a) q_a <= mem_a[addr_a];
        if (rden_b) q_b <= mem_b[addr_b];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_ctrl"}, longint'({busy_a, done_a, rden_a, sa.out_valid, sa.out_last}), 0);
        check({tag, "_addr"}, longint'(addr_a), 0);
        check({tag, "_data"}, longint'(sa.out_data), 0);
        check({tag, "_rowcol"}, longint'({sa.out_row, sa.out_col}), 0);
    endtask

    typedef struct {
        int pct;        // out_ready probability in percent
        int hold;       // cycles out_ready forced low after start
        int dup_beat;   // beat count at which a second start is pulsed (-1 none)
        bit rnd_mem;    // random BRAM contents instead of 3*i+1
        int exp_beats;
        int exp_dones;
        int exp_first;  // cycle of first out_valid after the start cycle
        int exp_last;   // cycle of the final beat (-1 when ready is random)
    } scen_t;

    scen_t tbl [5];

    task automatic run_a(input scen_t s, input string tag);
        logic [31:0] exp_q [$];
        int k = 0, beats = 0, issued = 0, dones = 0, first = -1, last_k = -1, done_k = -1;
        int bad_data = 0, bad_addr = 0, bad_credit = 0, bad_stab = 0, bad_idle = 0;
        bit prev_stall = 0, dup_done = 0, pop = 0, fin = 0;
        logic [31:0] pd = '0;
        logic [7:0]  prc = '0;
        logic        plast = 1'b0;

        for (int i = 0; i < WA; i++) mem_a[i] = s.rnd_mem ? $urandom : 32'(i * 3 + 1);
        for (int i = 0; i < WA; i++) exp_q.push_back(mem_a[i]);

        @(negedge clk);
        start_a = 1'b1;
        sa.out_ready = 1'b0;
        @(negedge clk);
        k = 1;
        while (!fin && k <= 4000) begin
            start_a = 1'b0;
            if (s.dup_beat >= 0 && !dup_done && beats == s.dup_beat) begin
                start_a  = 1'b1;
                dup_done = 1'b1;
            end
            sa.out_ready = (k <= s.hold) ? 1'b0 : ($urandom_range(99) < s.pct);
            #1;
            pop = sa.out_valid && sa.out_ready;
            if (rden_a) begin
                if (int'(addr_a) != issued) bad_addr++;
                if (issued + 1 - beats - int'(pop) > 2) bad_credit++;
                issued++;
            end
            if (s.hold > 0 && k == s.hold) begin
                check({tag, "_hold_reads"}, issued, 2);
                check({tag, "_hold_valid"}, longint'(sa.out_valid), 1);
                check({tag, "_hold_word0"}, longint'(sa.out_data), longint'(exp_q[0]));
            end
            if (sa.out_valid && !busy_a) bad_idle++;
            if (sa.out_valid && first < 0) first = k;
            if (prev_stall && (!sa.out_valid || sa.out_data !== pd ||
                               {sa.out_row, sa.out_col} !== prc || sa.out_last !== plast))
                bad_stab++;
            prev_stall = sa.out_valid && !sa.out_ready;
            pd    = sa.out_data;
            prc   = {sa.out_row, sa.out_col};
            plast = sa.out_last;
            if (pop) begin
                if (beats >= int'(WA) || sa.out_data !== exp_q[beats] ||
                    sa.out_row !== 4'(beats / 16) || sa.out_col !== 4'(beats % 16) ||
                    sa.out_last !== (beats == int'(WA) - 1))
                    bad_data++;
                beats++;
                last_k = k;
            end
            if (done_a) begin
                dones++;
                done_k = k;
            end
            if (dones > 0 && k >= done_k + 3) fin = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        start_a = 1'b0;
        sa.out_ready = 1'b0;

        check({tag, "_beats"}, beats, s.exp_beats);
        check({tag, "_dones"}, dones, s.exp_dones);
        check({tag, "_data_errs"}, bad_data, 0);
        check({tag, "_addr_errs"}, bad_addr, 0);
        check({tag, "_credit_errs"}, bad_credit, 0);
        check({tag, "_stall_errs"}, bad_stab, 0);
        check({tag, "_idle_valid"}, bad_idle, 0);
        check({tag, "_reads"}, issued, int'(WA));
        check({tag, "_first_valid"}, first, s.exp_first);
        check({tag, "_done_after_last"}, done_k, last_k + 1);
        check({tag, "_busy_end"}, longint'(busy_a), 0);
        if (s.exp_last >= 0) check({tag, "_last_cycle"}, last_k, s.exp_last);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int beats, k, dones, done_k, last_k, bad, max_addr;
        bit fin;

        tbl[0] = '{100, 0,  -1, 1'b0, 256, 1, 3, 258};
        tbl[1] = '{30,  0,  -1, 1'b1, 256, 1, 3, -1};
        tbl[2] = '{100, 20, -1, 1'b0, 256, 1, 3, 276};
        tbl[3] = '{100, 0, 100, 1'b0, 256, 1, 3, 258};
        tbl[4] = '{60,  0,  37, 1'b1, 256, 1, 3, -1};

        sa.out_ready = 1'b0;
        sb.out_ready = 1'b0;
        for (int i = 0; i < WA; i++) mem_a[i] = '0;
        for (int i = 0; i < WB; i++) mem_b[i] = '0;

        repeat (3) @(negedge clk);
        #1;
        check_zero_a("reset");
        check("reset_b_valid", longint'({sb.out_valid, busy_b, rden_b}), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            run_a(tbl[t], $sformatf("scen%0d", t));
            repeat (3) @(negedge clk);
        end

        // Abort mid-stream at beat 50, then restart from address 0.
        for (int i = 0; i < WA; i++) mem_a[i] = 32'(i * 3 + 1);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        sa.out_ready = 1'b1;
        beats = 0;
        k = 0;
        while (beats < 50 && k < 1000) begin
            #1;
            if (sa.out_valid) beats++;
            @(negedge clk);
            k++;
        end
        #1;
        check("abort_valid_before", longint'(sa.out_valid), 1);
        rst = 1'b0;
        #1;
        check_zero_a("abort");
        @(negedge clk);
        rst = 1'b1;
        sa.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        run_a(tbl[0], "restart");

        // Small build: N=4, 16-bit words.
        for (int i = 0; i < WB; i++) mem_b[i] = 16'(i * 3 + 1);
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        beats = 0; dones = 0; done_k = -1; last_k = -1; bad = 0; max_addr = 0;
        k = 1;
        fin = 1'b0;
        while (!fin && k <= 1000) begin
            sb.out_ready = ($urandom_range(99) < 50);
            #1;
            if (rden_b && int'(addr_b) > max_addr) max_addr = int'(addr_b);
            if (sb.out_valid && sb.out_ready) begin
                if (beats >= int'(WB) || sb.out_data !== 16'(beats * 3 + 1) ||
                    sb.out_row !== 2'(beats / 4) || sb.out_col !== 2'(beats % 4) ||
                    sb.out_last !== (beats == int'(WB) - 1))
                    bad++;
                beats++;
                last_k = k;
            end
            if (done_b) begin
                dones++;
                done_k = k;
            end
            if (dones > 0 && k >= done_k + 3) fin = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        sb.out_ready = 1'b0;
        check("n4_beats", beats, int'(WB));
        check("n4_data_errs", bad, 0);
        check("n4_dones", dones, 1);
        check("n4_done_after_last", done_k, last_k + 1);
        check("n4_max_addr", max_addr, int'(WB) - 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
- Downstream stage of the matrix-multiply compute unit.
- After the compute unit signals completion, this block reads the N*N 32-bit result words from the result BRAM read port in row-major order (address = row*N + col).
- Words leave on a valid/ready output stream with full backpressure support and an end-of-matrix marker.
- Absorbs the 1-cycle BRAM read latency with a 2-entry output buffer, so it sustains one word per cycle when out_ready stays high.

Parameters:
- N, 16, matrix dimension; N*N words are streamed per job.
- DATA_W, 32, result word width.
- ADDR_W, $clog2(N*N), BRAM address width (8 at N=16).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse to begin streaming; driven by the compute unit's done
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the final word handshake
- mem_addr  output  ADDR_W  result BRAM read address
- mem_rden  output  1  read issued this cycle
- mem_q  input  DATA_W  BRAM read data; valid exactly 1 cycle after mem_rden
- out_data  output  DATA_W  stream data
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready from the consumer
- out_last  output  1  high with the word at address N*N-1
- out_row  output  $clog2(N)  row index of out_data
- out_col  output  $clog2(N)  column index of out_data

Behaviour:
- Reset (rst low, async): state IDLE; busy=0, done=0, mem_rden=0, mem_addr=0, out_valid=0, out_last=0, out_data/out_row/out_col=0; buffer emptied; all counters 0.
- States: IDLE -> STREAM -> DRAIN -> IDLE.
- IDLE: start=1 moves to STREAM and clears rd_cnt (ADDR_W+1 bits, range 0..N*N).
- STREAM:
  - Issue a read (mem_rden=1, mem_addr=rd_cnt[ADDR_W-1:0], rd_cnt++) when rd_cnt < N*N and occupancy + inflight - pop < 2.
  - pop = out_valid & out_ready in the same cycle.
  - inflight = mem_rden registered one cycle.
  - When rd_cnt reaches N*N, go to DRAIN.
- DRAIN: no reads are issued. The block stays here until the buffer is empty and inflight=0, then goes to IDLE with done=1 for that one cycle.
- Buffer capture:
  - When inflight=1, mem_q is pushed together with its address. The address comes from a delayed copy of mem_addr.
  - The credit rule guarantees no overflow, so the buffer never drops data.
- Output:
  - out_valid = buffer non-empty.
  - out_data, out_row, out_col and out_last come from the head entry. out_last = (head addr == N*N-1).
  - Data, row, col and last stay stable while out_valid=1 and out_ready=0.
- Latency: start sampled at cycle T -> first mem_rden at T+1 -> out_valid at T+3.
  - With out_ready held high, one word per cycle: final beat at T+3+N*N-1, done at the next cycle.
- Simultaneous push and pop on a full or single-entry buffer is legal; occupancy is unchanged.
- start while busy is ignored. There is no queuing and no restart.
- out_valid never asserts in IDLE.
- out_ready is a don't-care when out_valid=0.
- rst asserted mid-stream aborts immediately to the reset state. The next start restarts at address 0.
- Address wrap: rd_cnt never exceeds N*N, and mem_addr holds its last value when no read is issued.

Decomposition:
- Shared package mm_pkg holds:
  - default N, DATA_W and ADDR_W localparams;
  - the streamer_state_t enum (IDLE, STREAM, DRAIN);
  - a buffer entry struct {data, addr}.
- One sub-module: fifo2, a parameterised 2-entry synchronous FIFO with push/pop/full/empty/count, same async active-low rst.
- The credit logic stays in result_streamer.

Test Plan:
- BRAM model holds mem[i]=i*3+1, out_ready=1, pulse start -> 256 beats with out_data=1,4,...,766; row/col match i/16, i%16; out_last only on beat 255; first out_valid 3 cycles after start; done 1 cycle after the last beat.
- out_ready random at 30% duty -> same 256 values in order, no duplicates or drops, out_data stable while stalled, mem_rden never issued when occupancy+inflight would exceed 2.
- out_ready held low 20 cycles after start -> exactly 2 reads issued, out_valid=1 holding word 0; release -> stream completes normally.
- Second start pulse at beat 100 -> ignored; exactly 256 beats and a single done pulse.
- rst low at beat 50 with out_valid=1 -> all outputs 0 immediately; new start -> stream restarts at addr 0, value 1.
- N=4, DATA_W=16 build -> 16 beats, out_last on beat 15, ADDR_W=4, done after beat 15.
